// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand request side and result side.
// The overflow signal exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_A;
  logic [WIDTH-1:0] data_B;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, data_A, data_B, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, data_A, data_B, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry register, LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             carry_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             fa_s;
  logic             fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_r;
`endif

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake flags are registered alongside the state so they never see
  // a combinational path from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_r       <= '0;
      cnt         <= '0;
      c           <= 1'b0;
      carry_r     <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.data_A;
            b_sr       <= bus.data_B;
            c          <= bus.carry_in;
            sum_r      <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          c     <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // On the MSB cycle c is the carry into bit WIDTH-1 and fa_co the carry out.
            carry_r     <= fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_r       <= c ^ fa_co;
`endif
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_r;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.overflow  = ovf_r;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8) against an arithmetic reference.
`timescale 1ns/1ps
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold);
    logic [W:0] r;
    int n;
    r = ref_add(a, b, cin);
    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.data_A    = a;
    bus.data_B    = b;
    bus.carry_in  = cin;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.data_A    = W'($urandom);
    bus.data_B    = W'($urandom);
    bus.carry_in  = 1'($urandom);
    check("in_ready_busy", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(W));
    check("sum", 64'(bus.sum), 64'(r[W-1:0]));
    check("carry_out", 64'(bus.carry_out), 64'(r[W]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("overflow", 64'(bus.overflow), 64'(ref_ovf(a, b, cin)));
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.data_A   = W'($urandom);
      bus.data_B   = W'($urandom);
      @(negedge clk);
      check("hold_sum", 64'(bus.sum), 64'(r[W-1:0]));
      check("hold_carry", 64'(bus.carry_out), 64'(r[W]));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("post_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data_A    = '0;
    bus.data_B    = '0;
    bus.carry_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_carry", 64'(bus.carry_out), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst_overflow", 64'(bus.overflow), 64'd0);
`endif
    rst = 1'b0;

    run_op(8'h3C, 8'h0F, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h5A, 8'h33, 1'b1, 5);

    // Abort mid-operation: three shift edges of 0xAA + 0x55, then reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_A   = 8'hAA;
    bus.data_B   = 8'h55;
    bus.carry_in = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_sum", 64'(bus.sum), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op(8'h01, 8'h02, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
